// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage sitting right after execute.
//
// Takes the registered ALU result, store data and destination fields from
// execute. A non-memory op is registered straight through to the writeback /
// forwarding outputs in one cycle. An aligned load or store issues a single
// request on the data-memory req/ack bus and holds the pipeline (busy) until
// the ack arrives. A misaligned load or store sets a sticky error flag and is
// dropped without touching the bus.
//
// Handshake: dmem_req rises on the edge that accepts an aligned memory op.
// From then on req/we/addr/wdata stay constant until the edge on which
// dmem_ack=1 is sampled, after which req drops. dmem_rdata is valid only
// alongside dmem_ack. While busy is high the upstream stage holds its op
// stable, and that op is consumed on the first cycle busy is low.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   result_in             ALU result, which is also the memory address
//   mem_write_data_in     store data
//   write_reg_in          destination register
//   reg_write_in          op writes a register
//   mem_write_in          op is a store (wins if mem_read_in is also high)
//   mem_read_in           op is a load
//   dmem_req/we/addr/wdata  registered bus request
//   dmem_rdata, dmem_ack  bus response
//   result_mem, write_reg_mem, reg_write_mem  registered writeback/forwarding
//   busy                  high while a bus access is outstanding
//   misalign_err          sticky misaligned-access flag
module mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       result_in,
  input  logic [31:0]       mem_write_data_in,
  input  logic [4:0]        write_reg_in,
  input  logic              reg_write_in,
  input  logic              mem_write_in,
  input  logic              mem_read_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [31:0]       result_mem,
  output logic [4:0]        write_reg_mem,
  output logic              reg_write_mem,
  output logic              busy,
  output logic              misalign_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t              state_q;
  logic                dmem_req_q;
  logic                dmem_we_q;
  logic [ADDR_W-1:0]   dmem_addr_q;
  logic [31:0]         dmem_wdata_q;
  logic [31:0]         result_q;
  logic [4:0]          write_reg_q;
  logic                reg_write_q;
  logic                misalign_q;
  // Fields of the outstanding memory op, needed when the ack returns.
  logic [4:0]          lat_dest_q;
  logic                lat_reg_write_q;
  logic                lat_load_q;

  logic is_mem_op;
  logic aligned;

  assign is_mem_op = mem_read_in | mem_write_in;
  assign aligned   = (result_in[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_wdata_q    <= '0;
      result_q        <= '0;
      write_reg_q     <= '0;
      reg_write_q     <= 1'b0;
      misalign_q      <= 1'b0;
      lat_dest_q      <= '0;
      lat_reg_write_q <= 1'b0;
      lat_load_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!is_mem_op) begin
            result_q    <= result_in;
            write_reg_q <= write_reg_in;
            reg_write_q <= reg_write_in && (write_reg_in != 5'd0);
          end else if (aligned) begin
            dmem_req_q      <= 1'b1;
            dmem_we_q       <= mem_write_in;
            dmem_addr_q     <= result_in[ADDR_W-1:0];
            dmem_wdata_q    <= mem_write_data_in;
            lat_dest_q      <= write_reg_in;
            lat_reg_write_q <= reg_write_in;
            // Read+write together is a store, so it never writes back.
            lat_load_q      <= mem_read_in & ~mem_write_in;
            reg_write_q     <= 1'b0;
            state_q         <= ACCESS;
          end else begin
            misalign_q  <= 1'b1;
            reg_write_q <= 1'b0;
          end
        end
        ACCESS: begin
          reg_write_q <= 1'b0;
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            state_q    <= IDLE;
            if (lat_load_q) begin
              result_q    <= dmem_rdata;
              write_reg_q <= lat_dest_q;
              reg_write_q <= lat_reg_write_q && (lat_dest_q != 5'd0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q == ACCESS);
  assign dmem_req      = dmem_req_q;
  assign dmem_we       = dmem_we_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_wdata    = dmem_wdata_q;
  assign result_mem    = result_q;
  assign write_reg_mem = write_reg_q;
  assign reg_write_mem = reg_write_q;
  assign misalign_err  = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases followed by random op streams, each
// compared against a transaction-level model of the architectural outputs.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result_in;
  logic [31:0] mem_write_data_in;
  logic [4:0]  write_reg_in;
  logic        reg_write_in;
  logic        mem_write_in;
  logic        mem_read_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] result_mem;
  logic [4:0]  write_reg_mem;
  logic        reg_write_mem;
  logic        busy;
  logic        misalign_err;

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .result_in(result_in), .mem_write_data_in(mem_write_data_in),
    .write_reg_in(write_reg_in), .reg_write_in(reg_write_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .result_mem(result_mem), .write_reg_mem(write_reg_mem),
    .reg_write_mem(reg_write_mem), .busy(busy), .misalign_err(misalign_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model: what writeback should currently see.
  logic [31:0] m_result;
  logic [4:0]  m_wreg;
  logic        m_regw;
  logic        m_mis;
  logic        m_res_ok;   // result_mem has a defined value
  logic        m_wreg_ok;  // write_reg_mem has a defined value

  // scoreboard: expected load data, queued when the bus returns it
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_result = '0; m_wreg = '0; m_regw = 1'b0; m_mis = 1'b0;
    m_res_ok = 1'b1; m_wreg_ok = 1'b1;
  endtask

  // Checks for a cycle in which the stage is not holding the pipeline.
  task automatic check_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".req"}, 32'(dmem_req), 32'd0);
    chk({tag, ".we"}, 32'(dmem_we), 32'd0);
    chk({tag, ".regw"}, 32'(reg_write_mem), 32'(m_regw));
    chk({tag, ".mis"}, 32'(misalign_err), 32'(m_mis));
    if (m_res_ok) chk({tag, ".result"}, result_mem, m_result);
    if (m_wreg_ok) chk({tag, ".wreg"}, 32'(write_reg_mem), 32'(m_wreg));
  endtask

  task automatic check_access(input string tag, input logic [31:0] addr,
                              input logic we, input logic [31:0] wd);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".req"}, 32'(dmem_req), 32'd1);
    chk({tag, ".addr"}, dmem_addr, addr);
    chk({tag, ".we"}, 32'(dmem_we), 32'(we));
    chk({tag, ".wdata"}, dmem_wdata, wd);
    chk({tag, ".regw"}, 32'(reg_write_mem), 32'd0);
    chk({tag, ".mis"}, 32'(misalign_err), 32'(m_mis));
  endtask

  task automatic set_op(input logic [31:0] res, input logic [31:0] wd, input logic [4:0] wr,
                        input logic rw, input logic mw, input logic mr);
    result_in = res; mem_write_data_in = wd; write_reg_in = wr;
    reg_write_in = rw; mem_write_in = mw; mem_read_in = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one op on the first idle cycle and follow it to
  // completion. waits = number of ACCESS cycles before the ack cycle.
  // idle_ack drives a stray ack while the op is presented in IDLE.
  task automatic do_op(input string tag, input logic [31:0] res, input logic [31:0] wd,
                       input logic [4:0] wr, input logic rw, input logic mw, input logic mr,
                       input int waits, input logic [31:0] rd, input logic idle_ack);
    logic [31:0] got;
    set_op(res, wd, wr, rw, mw, mr);
    dmem_ack = idle_ack;
    dmem_rdata = $urandom;
    tick();
    dmem_ack = 1'b0;
    if (!mw && !mr) begin
      m_result = res; m_res_ok = 1'b1;
      m_wreg = wr; m_wreg_ok = 1'b1;
      m_regw = rw && (wr != 5'd0);
      check_idle(tag);
    end else if (res[1:0] != 2'b00) begin
      m_mis = 1'b1; m_regw = 1'b0;
      m_res_ok = 1'b0; m_wreg_ok = 1'b0;
      check_idle(tag);
    end else begin
      for (int k = 0; k <= waits; k++) begin
        check_access(tag, res, mw, wd);
        // The stage must ignore whatever upstream shows during the access.
        set_op($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (k == waits) begin
          dmem_ack = 1'b1;
          dmem_rdata = rd;
          if (mr && !mw) exp_q.push_back(rd);
        end
        tick();
        dmem_ack = 1'b0;
      end
      if (mr && !mw) begin
        got = exp_q.pop_front();
        m_result = got; m_res_ok = 1'b1;
        m_wreg = wr; m_wreg_ok = 1'b1;
        m_regw = rw && (wr != 5'd0);
      end else begin
        m_regw = 1'b0;
        m_wreg_ok = 1'b0;
      end
      check_idle(tag);
    end
  endtask

  initial begin
    logic [31:0] r;
    int kind;
    rst = 1'b1;
    set_op('0, '0, '0, 1'b0, 1'b0, 1'b0);
    dmem_rdata = '0;
    dmem_ack = 1'b0;
    model_reset();
    tick();
    tick();
    chk("rst.result", result_mem, 32'd0);
    chk("rst.wreg", 32'(write_reg_mem), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    check_idle("rst");
    rst = 1'b0;

    // ALU pass-through
    do_op("alu", 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    // load with three ACCESS cycles
    do_op("load3", 32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 2, 32'hDEAD_BEEF, 1'b0);
    chk("load3.result_fixed", result_mem, 32'hDEAD_BEEF);

    // store with immediate ack while the next ALU op waits upstream
    set_op(32'h200, 32'hA5A5_A5A5, 5'd3, 1'b0, 1'b1, 1'b0);
    tick();
    check_access("st", 32'h200, 1'b1, 32'hA5A5_A5A5);
    set_op(32'h0000_0055, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    dmem_ack = 1'b1;
    dmem_rdata = $urandom;
    tick();
    dmem_ack = 1'b0;
    m_regw = 1'b0; m_wreg_ok = 1'b0;
    check_idle("st.done");
    tick();
    m_result = 32'h55; m_wreg = 5'd9; m_wreg_ok = 1'b1; m_regw = 1'b1;
    check_idle("held_alu");
    do_op("after_held", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);

    // destination x0
    do_op("x0_alu", 32'h77, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    do_op("x0_load", 32'h300, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 1, 32'h1357_9BDF, 1'b0);
    // read and write together behave as a store
    do_op("rw_both", 32'h404, 32'hCAFE_F00D, 5'd4, 1'b1, 1'b1, 1'b1, 0, 32'h0, 1'b0);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      r = $urandom & 32'hFFFF_FFFC;
      if (kind < 5)
        do_op("rnd_alu", $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'b0, 1'b0, 0, 32'h0, 1'($urandom_range(0, 1)));
      else if (kind < 7)
        do_op("rnd_ld", r, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'b0, 1'b1, $urandom_range(0, 3), $urandom, 1'b0);
      else if (kind < 9)
        do_op("rnd_st", r, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'b1, 1'b0, $urandom_range(0, 3), $urandom, 1'b0);
      else
        do_op("rnd_mis", r | 32'($urandom_range(1, 3)), $urandom, 5'($urandom_range(1, 31)),
              1'b1, 1'($urandom_range(0, 1)), 1'b1, 0, 32'h0, 1'b0);
    end

    // misaligned access, then confirm the flag survives later ops
    do_op("mis", 32'h102, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 0, 32'h0, 1'b0);
    chk("mis.flag", 32'(misalign_err), 32'd1);
    do_op("mis_alu", 32'h42, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    do_op("mis_ld", 32'h500, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1, 32'h0BAD_F00D, 1'b0);
    chk("mis.sticky", 32'(misalign_err), 32'd1);

    // reset in the middle of an access, then a late ack
    set_op(32'h600, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1);
    tick();
    check_access("rst_mid", 32'h600, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_idle("rst_mid.after");
    do_op("late_ack", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1);
    do_op("post_rst_ld", 32'h700, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 0, 32'h2468_ACE0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      r = $urandom & 32'hFFFF_FFFC;
      do_op("rnd2", r, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
            $urandom, 1'($urandom_range(0, 1)));
    end

    chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
